// File: rtl/pic_cmd_sequencer.sv
// pic_cmd_sequencer: 8259-style ICW1..ICW4 init sequencer and OCW1..OCW3 decoder; PIC_CASCADE_EN enables ICW3/cascade.
// Latency: registers update on the write edge, ocw2Valid pulses the next cycle, read selects are combinational; wr is never stalled.
module pic_cmd_sequencer #(
    parameter int NUM_IRQ = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr,
    input  logic               rd,
    input  logic               A0,
    input  logic [7:0]         DBus,
    output logic               ltim,
    output logic               sngl,
    output logic               ic4,
    output logic [4:0]         vectorBase,
    output logic [7:0]         slaveReg,
    output logic               sfnm,
    output logic               bufMode,
    output logic               ms,
    output logic               aeoi,
    output logic [NUM_IRQ-1:0] maskReg,
    output logic               smm,
    output logic               ocw2Valid,
    output logic               ocw2R,
    output logic               ocw2SL,
    output logic               ocw2EOI,
    output logic [2:0]         ocw2Level,
    output logic               initDone,
    output logic               readIRR,
    output logic               readISR,
    output logic               readIMR,
    output logic               readPoll
);

    typedef enum logic [2:0] {
        UNINIT,
        WAIT_ICW2,
        WAIT_ICW3,
        WAIT_ICW4,
        READY
    } state_t;

    localparam logic [3:0] NIRQ = 4'(NUM_IRQ);

    state_t state;
    logic   ris;
    logic   poll;
    logic   pollSeen;
    logic   icw1Wr;
    logic   ocw2Drop;

    assign icw1Wr   = wr & ~A0 & DBus[4];
    assign ocw2Drop = DBus[6] & ({1'b0, DBus[2:0]} >= NIRQ);

    assign readIMR  = rd & A0;
    assign readPoll = rd & ~A0 & poll;
    assign readIRR  = rd & ~A0 & ~poll & ~ris;
    assign readISR  = rd & ~A0 & ~poll & ris;

`ifdef PIC_CASCADE_EN
    logic       snglReg;
    logic [7:0] slaveQ;

    assign sngl     = snglReg;
    assign slaveReg = slaveQ;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snglReg <= 1'b0;
            slaveQ  <= 8'h00;
        end else if (icw1Wr) begin
            snglReg <= DBus[1];
        end else if (wr && A0 && state == WAIT_ICW3) begin
            slaveQ <= DBus;
        end
    end
`else
    // Single-PIC build: constant sngl makes the FSM skip WAIT_ICW3.
    assign sngl     = 1'b1;
    assign slaveReg = 8'h00;
`endif

    // RR is forced to 1 by ICW1 and only ever rewritten with 1, so RIS alone picks IRR vs ISR.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= UNINIT;
            ltim       <= 1'b0;
            ic4        <= 1'b0;
            vectorBase <= 5'd0;
            sfnm       <= 1'b0;
            bufMode    <= 1'b0;
            ms         <= 1'b0;
            aeoi       <= 1'b0;
            maskReg    <= '0;
            smm        <= 1'b0;
            ocw2Valid  <= 1'b0;
            ocw2R      <= 1'b0;
            ocw2SL     <= 1'b0;
            ocw2EOI    <= 1'b0;
            ocw2Level  <= 3'd0;
            initDone   <= 1'b0;
            ris        <= 1'b0;
            poll       <= 1'b0;
            pollSeen   <= 1'b0;
        end else begin
            ocw2Valid <= 1'b0;
            pollSeen  <= readPoll;
            if (pollSeen && !rd) begin
                poll <= 1'b0;
            end
            if (icw1Wr) begin
                ltim     <= DBus[3];
                ic4      <= DBus[0];
                maskReg  <= '0;
                smm      <= 1'b0;
                poll     <= 1'b0;
                ris      <= 1'b0;
                initDone <= 1'b0;
                state    <= WAIT_ICW2;
                if (!DBus[0]) begin
                    sfnm    <= 1'b0;
                    bufMode <= 1'b0;
                    ms      <= 1'b0;
                    aeoi    <= 1'b0;
                end
            end else if (wr) begin
                case (state)
                    WAIT_ICW2: if (A0) begin
                        vectorBase <= DBus[7:3];
                        if (!sngl) begin
                            state <= WAIT_ICW3;
                        end else if (ic4) begin
                            state <= WAIT_ICW4;
                        end else begin
                            state    <= READY;
                            initDone <= 1'b1;
                        end
                    end
                    WAIT_ICW3: if (A0) begin
                        if (ic4) begin
                            state <= WAIT_ICW4;
                        end else begin
                            state    <= READY;
                            initDone <= 1'b1;
                        end
                    end
                    WAIT_ICW4: if (A0) begin
                        sfnm     <= DBus[4];
                        bufMode  <= DBus[3];
                        ms       <= DBus[2];
                        aeoi     <= DBus[1];
                        state    <= READY;
                        initDone <= 1'b1;
                    end
                    READY: begin
                        if (A0) begin
                            maskReg <= DBus[NUM_IRQ-1:0];
                        end else if (!DBus[3]) begin
                            if (!ocw2Drop) begin
                                ocw2Valid <= 1'b1;
                                ocw2R     <= DBus[7];
                                ocw2SL    <= DBus[6];
                                ocw2EOI   <= DBus[5];
                                ocw2Level <= DBus[2:0];
                            end
                        end else begin
                            if (DBus[6]) begin
                                smm <= DBus[5];
                            end
                            if (DBus[1]) begin
                                ris <= DBus[0];
                            end
                            poll <= DBus[2];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pic_cmd_sequencer.sv
// Directed bench for pic_cmd_sequencer: NUM_IRQ=8 and NUM_IRQ=4 instances share stimulus; OCW2 pulses go through a scoreboard.
module tb_pic_cmd_sequencer;

`ifdef PIC_CASCADE_EN
    localparam bit CAS = 1'b1;
`else
    localparam bit CAS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, wr, rd, A0;
    logic [7:0] DBus;

    logic       ltim, sngl, ic4, sfnm, bufMode, ms, aeoi, smm;
    logic [4:0] vectorBase;
    logic [7:0] slaveReg, maskReg;
    logic       ocw2Valid, ocw2R, ocw2SL, ocw2EOI, initDone;
    logic [2:0] ocw2Level;
    logic       readIRR, readISR, readIMR, readPoll;

    logic       ltim4, sngl4, ic44, sfnm4, bufMode4, ms4, aeoi4, smm4;
    logic [4:0] vectorBase4;
    logic [7:0] slaveReg4;
    logic [3:0] maskReg4;
    logic       ocw2Valid4, ocw2R4, ocw2SL4, ocw2EOI4, initDone4;
    logic [2:0] ocw2Level4;
    logic       readIRR4, readISR4, readIMR4, readPoll4;

    int         vectors = 0;
    int         miscompares = 0;
    logic [5:0] q8[$];
    logic [5:0] q4[$];
    logic [5:0] e8, e4;

    pic_cmd_sequencer #(.NUM_IRQ(8)) u8 (
        .clk(clk), .reset(reset), .wr(wr), .rd(rd), .A0(A0), .DBus(DBus),
        .ltim(ltim), .sngl(sngl), .ic4(ic4), .vectorBase(vectorBase), .slaveReg(slaveReg),
        .sfnm(sfnm), .bufMode(bufMode), .ms(ms), .aeoi(aeoi), .maskReg(maskReg), .smm(smm),
        .ocw2Valid(ocw2Valid), .ocw2R(ocw2R), .ocw2SL(ocw2SL), .ocw2EOI(ocw2EOI),
        .ocw2Level(ocw2Level), .initDone(initDone),
        .readIRR(readIRR), .readISR(readISR), .readIMR(readIMR), .readPoll(readPoll)
    );

    pic_cmd_sequencer #(.NUM_IRQ(4)) u4 (
        .clk(clk), .reset(reset), .wr(wr), .rd(rd), .A0(A0), .DBus(DBus),
        .ltim(ltim4), .sngl(sngl4), .ic4(ic44), .vectorBase(vectorBase4), .slaveReg(slaveReg4),
        .sfnm(sfnm4), .bufMode(bufMode4), .ms(ms4), .aeoi(aeoi4), .maskReg(maskReg4), .smm(smm4),
        .ocw2Valid(ocw2Valid4), .ocw2R(ocw2R4), .ocw2SL(ocw2SL4), .ocw2EOI(ocw2EOI4),
        .ocw2Level(ocw2Level4), .initDone(initDone4),
        .readIRR(readIRR4), .readISR(readISR4), .readIMR(readIMR4), .readPoll(readPoll4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic ei, input logic [4:0] evb,
                             input logic [7:0] esr, input logic [3:0] eicw4,
                             input logic [7:0] emask, input logic esmm);
        chk({tag, " initDone"}, 32'(initDone), 32'(ei));
        chk({tag, " vectorBase"}, 32'(vectorBase), 32'(evb));
        chk({tag, " slaveReg"}, 32'(slaveReg), 32'(esr));
        chk({tag, " icw4 fields"}, 32'({sfnm, bufMode, ms, aeoi}), 32'(eicw4));
        chk({tag, " maskReg"}, 32'(maskReg), 32'(emask));
        chk({tag, " smm"}, 32'(smm), 32'(esmm));
    endtask

    task automatic wr_cmd(input logic a0, input logic [7:0] d);
        @(posedge clk); #1;
        wr = 1'b1; A0 = a0; DBus = d;
        @(posedge clk); #1;
        wr = 1'b0; A0 = 1'b0; DBus = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input string name, input logic a0, input logic [3:0] esel);
        rd = 1'b1; A0 = a0;
        #1;
        chk(name, 32'({readIRR, readISR, readIMR, readPoll}), 32'(esel));
        rd = 1'b0; A0 = 1'b0;
    endtask

    // Scoreboard monitor: every ocw2Valid cycle must consume exactly one queued command.
    always @(negedge clk) begin
        if (ocw2Valid) begin
            vectors++;
            if (q8.size() == 0) begin
                miscompares++;
                $display("FAIL ocw2 n8 unexpected pulse: got %b, expected none",
                         {ocw2R, ocw2SL, ocw2EOI, ocw2Level});
            end else begin
                e8 = q8.pop_front();
                if ({ocw2R, ocw2SL, ocw2EOI, ocw2Level} !== e8) begin
                    miscompares++;
                    $display("FAIL ocw2 n8 fields: got %b, expected %b",
                             {ocw2R, ocw2SL, ocw2EOI, ocw2Level}, e8);
                end
            end
        end
        if (ocw2Valid4) begin
            vectors++;
            if (q4.size() == 0) begin
                miscompares++;
                $display("FAIL ocw2 n4 unexpected pulse: got %b, expected none",
                         {ocw2R4, ocw2SL4, ocw2EOI4, ocw2Level4});
            end else begin
                e4 = q4.pop_front();
                if ({ocw2R4, ocw2SL4, ocw2EOI4, ocw2Level4} !== e4) begin
                    miscompares++;
                    $display("FAIL ocw2 n4 fields: got %b, expected %b",
                             {ocw2R4, ocw2SL4, ocw2EOI4, ocw2Level4}, e4);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; wr = 1'b0; rd = 1'b0; A0 = 1'b0; DBus = 8'h00;
        idle(3);
        chk_state("reset", 1'b0, 5'd0, 8'h00, 4'b0000, 8'h00, 1'b0);
        chk("reset icw1 fields", 32'({ltim, sngl, ic4}), 32'({1'b0, ~CAS, 1'b0}));
        chk("reset ocw2", 32'({ocw2Valid, ocw2R, ocw2SL, ocw2EOI, ocw2Level}), 32'd0);
        reset = 1'b0;
        idle(1);

        // Writes before any ICW1 are ignored
        wr_cmd(1'b1, 8'hFF);
        wr_cmd(1'b0, 8'h08);
        chk_state("uninit ignore", 1'b0, 5'd0, 8'h00, 4'b0000, 8'h00, 1'b0);

        // Single, with ICW4
        wr_cmd(1'b0, 8'h13);
        chk("icw1 13 fields", 32'({ltim, sngl, ic4}), 32'(3'b011));
        chk("icw1 13 initDone", 32'(initDone), 32'd0);
        wr_cmd(1'b1, 8'h20);
        chk("icw2 20 vectorBase", 32'(vectorBase), 32'(5'b00100));
        chk("icw2 20 initDone", 32'(initDone), 32'd0);
        wr_cmd(1'b1, 8'h03);
        chk_state("icw4 03", 1'b1, 5'd4, 8'h00, 4'b0001, 8'h00, 1'b0);

        // Cascade sequence; A0=0 non-ICW1 write in WAIT_ICW2 must be ignored
        wr_cmd(1'b0, 8'h11);
        chk("icw1 11 fields", 32'({ltim, sngl, ic4}), 32'({1'b0, ~CAS, 1'b1}));
        chk("icw1 11 initDone", 32'(initDone), 32'd0);
        wr_cmd(1'b0, 8'h08);
        chk("wait icw2 ignore vb", 32'(vectorBase), 32'd4);
        wr_cmd(1'b1, 8'h40);
        chk("icw2 40 vectorBase", 32'(vectorBase), 32'd8);
        if (CAS) wr_cmd(1'b1, 8'h04);
        wr_cmd(1'b1, 8'h1D);
        chk_state("icw4 1D", 1'b1, 5'd8, CAS ? 8'h04 : 8'h00, 4'b1110, 8'h00, 1'b0);
        wr_cmd(1'b1, 8'hA5);
        chk("ocw1 A5 mask8", 32'(maskReg), 32'hA5);
        chk("ocw1 A5 mask4", 32'(maskReg4), 32'h5);

        // OCW2: {R,SL,EOI,Level}; SL with level >= 4 dropped by the 4-line instance only
        q8.push_back(6'b011_011); q4.push_back(6'b011_011);
        wr_cmd(1'b0, 8'h63);
        idle(2);
        q8.push_back(6'b011_110);
        wr_cmd(1'b0, 8'h66);
        idle(2);
        q8.push_back(6'b101_000); q4.push_back(6'b101_000);
        wr_cmd(1'b0, 8'hA0);
        q8.push_back(6'b001_111); q4.push_back(6'b001_111);
        wr_cmd(1'b0, 8'h27);
        idle(2);
        chk("ocw2 q8 drained", 32'(q8.size()), 32'd0);
        chk("ocw2 q4 drained", 32'(q4.size()), 32'd0);

        // OCW3 read-register select and special mask mode
        wr_cmd(1'b0, 8'h0B);
        chk("no rd sel", 32'({readIRR, readISR, readIMR, readPoll}), 32'd0);
        rd_chk("ocw3 0B isr", 1'b0, 4'b0100);
        wr_cmd(1'b0, 8'h08);
        rd_chk("ocw3 08 keeps ris", 1'b0, 4'b0100);
        rd_chk("imr select", 1'b1, 4'b0010);
        wr_cmd(1'b0, 8'h0A);
        rd_chk("ocw3 0A irr", 1'b0, 4'b1000);
        wr_cmd(1'b0, 8'h0B);
        wr_cmd(1'b0, 8'h68);
        chk("ocw3 68 smm", 32'(smm), 32'd1);
        wr_cmd(1'b0, 8'h28);
        chk("ocw3 28 smm kept", 32'(smm), 32'd1);

        // Poll is one-shot across a 2-cycle read
        wr_cmd(1'b0, 8'h0C);
        rd = 1'b1; A0 = 1'b0;
        #1;
        chk("poll start", 32'({readIRR, readISR, readIMR, readPoll}), 32'(4'b0001));
        idle(1);
        chk("poll cyc1", 32'({readIRR, readISR, readIMR, readPoll}), 32'(4'b0001));
        idle(1);
        chk("poll cyc2", 32'({readIRR, readISR, readIMR, readPoll}), 32'(4'b0001));
        rd = 1'b0;
        idle(1);
        rd_chk("after poll isr", 1'b0, 4'b0100);

        // Restart mid-sequence with ICW1, then async reset in WAIT_ICW4
        wr_cmd(1'b0, 8'h11);
        chk("restart mask cleared", 32'(maskReg), 32'd0);
        chk("restart smm cleared", 32'(smm), 32'd0);
        wr_cmd(1'b1, 8'h48);
        wr_cmd(1'b0, 8'h17);
        chk("icw1 17 fields", 32'({ltim, sngl, ic4}), 32'(3'b011));
        chk_state("icw1 17", 1'b0, 5'd9, CAS ? 8'h04 : 8'h00, 4'b1110, 8'h00, 1'b0);
        wr_cmd(1'b1, 8'h28);
        chk("restart icw2 vb", 32'(vectorBase), 32'd5);
        chk("restart initDone", 32'(initDone), 32'd0);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        chk_state("async reset", 1'b0, 5'd0, 8'h00, 4'b0000, 8'h00, 1'b0);
        chk("async reset icw1", 32'({ltim, sngl, ic4}), 32'({1'b0, ~CAS, 1'b0}));
        idle(1);
        reset = 1'b0;
        wr_cmd(1'b1, 8'h00);
        chk("post reset uninit", 32'({initDone, vectorBase}), 32'd0);

        // Minimal ICW1 (no ICW4) goes straight to READY after ICW2
        wr_cmd(1'b0, 8'h12);
        wr_cmd(1'b1, 8'hF8);
        chk("short init vb", 32'(vectorBase), 32'd31);
        chk("short init initDone", 32'(initDone), 32'd1);

        idle(2);
        chk("final q8 empty", 32'(q8.size()), 32'd0);
        chk("final q4 empty", 32'(q4.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pic_cmd_sequencer.md
Name: pic_cmd_sequencer

Overview:
- Clocked command decoder and initialisation sequencer for the PIC core.
- Consumes raw CPU write/read strobes, A0 and DBus directly; no precomputed ICWn/OCWn flags.
- Runs the ICW1→ICW2→[ICW3]→[ICW4] sequence internally, then decodes OCW1–OCW3.
- Holds all mode and mask registers and drives read-path selects (IRR/ISR/IMR/poll) to the priority and data-bus blocks.

Parameters:
- NUM_IRQ, 8, interrupt lines served (1..8); sets maskReg width; ICW2/OCW fields stay 8259-format.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- wr  in  1  write strobe, one clk cycle per CPU write
- rd  in  1  read enable, level, held for the whole CPU read
- A0  in  1  address bit 0
- DBus  in  8  write data, sampled when wr=1
- ltim, sngl, ic4  out  1 each  ICW1 D3, D1, D0
- vectorBase  out  5  ICW2 D7:3
- slaveReg  out  8  ICW3 raw byte
- sfnm, buf, ms, aeoi  out  1 each  ICW4 D4, D3, D2, D1
- maskReg  out  NUM_IRQ  OCW1 D[NUM_IRQ-1:0]
- smm  out  1  special mask mode
- ocw2Valid  out  1  one-cycle pulse per accepted OCW2
- ocw2R, ocw2SL, ocw2EOI  out  1 each  OCW2 D7, D6, D5, valid with ocw2Valid
- ocw2Level  out  3  OCW2 D2:0, valid with ocw2Valid
- initDone  out  1  high in READY
- readIRR, readISR, readIMR, readPoll  out  1 each  combinational read selects

Behaviour:
- Reset (async): state UNINIT; every register output, ocw2* and initDone = 0; internal RR=1, RIS=0, P=0.
- States: UNINIT, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY. Transitions occur only on wr=1, at the clk edge of the write.
- ICW1 (wr, A0=0, D4=1): accepted in any state and restarts the sequence.
  - Loads ltim, sngl, ic4; clears maskReg, smm, P; sets RR=1, RIS=0.
  - If D0=0, clears sfnm, buf, ms, aeoi.
  - Next state WAIT_ICW2; initDone drops the following cycle.
- WAIT_ICW2, wr with A0=1: load vectorBase.
  - Next state: WAIT_ICW3 if sngl=0; else WAIT_ICW4 if ic4=1; else READY.
- WAIT_ICW3, wr with A0=1: load slaveReg. Next state WAIT_ICW4 if ic4=1, else READY.
- WAIT_ICW4, wr with A0=1: load sfnm, buf, ms, aeoi. Next state READY.
- Non-ICW1 writes with A0=0 while in UNINIT or WAIT_*: ignored, no state change. Writes with A0=1 in UNINIT: ignored.
- READY, wr with A0=1 (OCW1): maskReg <= DBus[NUM_IRQ-1:0].
- READY, A0=0, D4=0, D3=0 (OCW2): ocw2Valid=1 for exactly the next cycle with registered R/SL/EOI/Level.
  - If SL=1 and D2:0 >= NUM_IRQ: command dropped, no pulse.
- READY, A0=0, D4=0, D3=1 (OCW3):
  - If D6 (ESMM)=1: smm <= D5.
  - If D1 (RR)=1: RIS <= D0. If D1=0: RR/RIS unchanged.
  - P <= D2.
- Read selects (combinational, no latency):
  - readIMR = rd & A0.
  - readPoll = rd & ~A0 & P.
  - readIRR = rd & ~A0 & ~P & ~RIS.
  - readISR = rd & ~A0 & ~P & RIS.
- Poll is one-shot: P clears on the clk edge after rd falls from a poll read. The next read returns IRR/ISR per RIS.
- wr and rd in the same cycle: the write is processed; read selects use pre-write register values that cycle.
- Reset mid-sequence: returns to UNINIT; a full ICW sequence is required again.

Optional Feature:
- Macro PIC_CASCADE_EN.
- Defined: ICW3 handling as above; sngl follows ICW1 D1.
- Undefined: WAIT_ICW3 is never entered. ICW2 goes to WAIT_ICW4 or READY regardless of sngl. slaveReg is tied to 0 and sngl reads back as 1.

Test Plan:
- Reset, then ICW1=0x13, ICW2=0x20 (A0=1), ICW4=0x03 → vectorBase=5'b00100, aeoi=1, sfnm=0; initDone=1 one cycle after the ICW4 write; WAIT_ICW3 skipped.
- ICW1=0x11, ICW2=0x40, ICW3=0x04, ICW4=0x1D (cascade build) → slaveReg=0x04, sfnm=1, buf=1, ms=1; OCW1=0xA5 → maskReg=0xA5.
- In READY write OCW2=0x63 → ocw2Valid high exactly 1 cycle, R=0, SL=1, EOI=1, Level=3. With NUM_IRQ=4, OCW2=0x66 → no pulse.
- OCW3=0x0B, rd=1 with A0=0 → readISR=1. OCW3=0x08 (RR=0) → RIS still 1. rd with A0=1 → readIMR only.
- OCW3=0x0C, hold rd=1 with A0=0 for 2 cycles → readPoll=1 throughout. After rd falls, next read asserts readISR, not readPoll.
- Mid-sequence (WAIT_ICW3) write ICW1=0x17 → restart to WAIT_ICW2, maskReg=0, sfnm/buf/ms/aeoi unchanged (ic4=1); assert reset during WAIT_ICW4 → all outputs 0, UNINIT.
